// File: rtl/mii_frame_rx.sv
// MII receive frame engine: strips preamble/SFD, assembles bytes, checks CRC-32, drops FCS.
// Latency: payload byte k is presented the cycle after byte k+4 completes; status one cycle after rx_dv falls.
// Backpressure: none; the MII stream cannot be stalled, so output strobes must be consumed when presented.
//
// Ports: clk/reset_n (async active-low); rx_dv/rx_er/rxd MII receive inputs (low nibble first);
// rx_byte/rx_byte_valid/rx_sof payload stream; rx_eof strobe qualifies rx_crc_ok, rx_align_err,
// rx_len_err, rx_phy_err and rx_len, which hold until the next rx_eof.
module mii_frame_rx #(
    parameter int MIN_LEN = 64,
    parameter int MAX_LEN = 1518
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic        rx_dv,
    input  logic        rx_er,
    input  logic [3:0]  rxd,
    output logic [7:0]  rx_byte,
    output logic        rx_byte_valid,
    output logic        rx_sof,
    output logic        rx_eof,
    output logic        rx_crc_ok,
    output logic        rx_align_err,
    output logic        rx_len_err,
    output logic        rx_phy_err,
    output logic [10:0] rx_len
);

    localparam logic [10:0] MIN_L = 11'(MIN_LEN);
    localparam logic [10:0] MAX_L = 11'(MAX_LEN);

    typedef enum logic [1:0] {IDLE, PREAMBLE, DATA, DROP} state_t;

    state_t      state, state_nxt;
    logic        enter_data;
    logic        frame_end;

    logic        first_cyc;   // high only until the first edge after reset release
    logic        half_vld;
    logic [3:0]  half_nib;
    logic [7:0]  dly [4];     // dly[0] is the oldest byte
    logic [2:0]  dly_cnt;
    logic [31:0] crc;
    logic [10:0] len;
    logic        phy_err;
    logic        first_out;

    // Reflected CRC-32 update for one byte (poly 0x04C11DB7 reflected = 0xEDB88320).
    function automatic logic [31:0] crc_byte(input logic [31:0] c, input logic [7:0] d);
        logic [31:0] r;
        r = c ^ {24'h0, d};
        for (int i = 0; i < 8; i++) begin
            r = r[0] ? ((r >> 1) ^ 32'hEDB88320) : (r >> 1);
        end
        return r;
    endfunction

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt  = state;
        enter_data = 1'b0;
        frame_end  = 1'b0;
        case (state)
            IDLE: begin
                // A frame already in flight at reset release has lost its preamble; discard it.
                if (rx_dv) begin
                    state_nxt = (first_cyc || rxd != 4'h5) ? DROP : PREAMBLE;
                end
            end
            PREAMBLE: begin
                if (!rx_dv) begin
                    state_nxt = IDLE;
                end else if (rxd == 4'hD) begin
                    state_nxt  = DATA;
                    enter_data = 1'b1;
                end else if (rxd != 4'h5) begin
                    state_nxt = DROP;
                end
            end
            DATA: begin
                if (!rx_dv) begin
                    state_nxt = IDLE;
                    frame_end = 1'b1;
                end
            end
            DROP: begin
                if (!rx_dv) begin
                    state_nxt = IDLE;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            first_cyc     <= 1'b1;
            half_vld      <= 1'b0;
            half_nib      <= 4'h0;
            for (int i = 0; i < 4; i++) begin
                dly[i] <= 8'h00;
            end
            dly_cnt       <= 3'd0;
            crc           <= 32'hFFFFFFFF;
            len           <= 11'd0;
            phy_err       <= 1'b0;
            first_out     <= 1'b0;
            rx_byte       <= 8'h00;
            rx_byte_valid <= 1'b0;
            rx_sof        <= 1'b0;
            rx_eof        <= 1'b0;
            rx_crc_ok     <= 1'b0;
            rx_align_err  <= 1'b0;
            rx_len_err    <= 1'b0;
            rx_phy_err    <= 1'b0;
            rx_len        <= 11'd0;
        end else begin
            first_cyc     <= 1'b0;
            rx_byte_valid <= 1'b0;
            rx_sof        <= 1'b0;
            rx_eof        <= 1'b0;

            if (enter_data) begin
                half_vld  <= 1'b0;
                dly_cnt   <= 3'd0;
                crc       <= 32'hFFFFFFFF;
                len       <= 11'd0;
                phy_err   <= 1'b0;
                first_out <= 1'b1;
            end else if (state == DATA && rx_dv) begin
                if (rx_er) begin
                    phy_err <= 1'b1;
                end
                if (!half_vld) begin
                    half_nib <= rxd;
                    half_vld <= 1'b1;
                end else begin
                    half_vld <= 1'b0;
                    if (len != 11'h7FF) begin
                        len <= len + 11'd1;
                    end
                    dly[0] <= dly[1];
                    dly[1] <= dly[2];
                    dly[2] <= dly[3];
                    dly[3] <= {rxd, half_nib};
                    // Once four bytes are held back, each new byte releases the oldest one;
                    // the final four bytes (the FCS) are therefore never presented.
                    if (dly_cnt == 3'd4) begin
                        rx_byte       <= dly[0];
                        rx_byte_valid <= 1'b1;
                        rx_sof        <= first_out;
                        first_out     <= 1'b0;
                        crc           <= crc_byte(crc, dly[0]);
                    end else begin
                        dly_cnt <= dly_cnt + 3'd1;
                    end
                end
            end

            if (frame_end) begin
                half_vld     <= 1'b0;
                rx_eof       <= 1'b1;
                rx_align_err <= half_vld;
                // Held bytes are the FCS, first byte in dly[0] = CRC[7:0].
                rx_crc_ok    <= !half_vld && (len >= 11'd4) &&
                                (~crc == {dly[3], dly[2], dly[1], dly[0]});
                rx_len_err   <= (len < MIN_L) || (len > MAX_L);
                rx_phy_err   <= phy_err;
                rx_len       <= len;
            end
        end
    end

endmodule

// File: tb/tb_mii_frame_rx.sv
module tb_mii_frame_rx;

    logic        clk = 1'b0;
    logic        reset_n;
    logic        rx_dv;
    logic        rx_er;
    logic [3:0]  rxd;
    logic [7:0]  rx_byte;
    logic        rx_byte_valid;
    logic        rx_sof;
    logic        rx_eof;
    logic        rx_crc_ok;
    logic        rx_align_err;
    logic        rx_len_err;
    logic        rx_phy_err;
    logic [10:0] rx_len;

    mii_frame_rx #(.MIN_LEN(64), .MAX_LEN(1518)) dut (
        .clk          (clk),
        .reset_n      (reset_n),
        .rx_dv        (rx_dv),
        .rx_er        (rx_er),
        .rxd          (rxd),
        .rx_byte      (rx_byte),
        .rx_byte_valid(rx_byte_valid),
        .rx_sof       (rx_sof),
        .rx_eof       (rx_eof),
        .rx_crc_ok    (rx_crc_ok),
        .rx_align_err (rx_align_err),
        .rx_len_err   (rx_len_err),
        .rx_phy_err   (rx_phy_err),
        .rx_len       (rx_len)
    );

    always #20 clk = ~clk;

    typedef struct packed {
        logic        crc_ok;
        logic        align;
        logic        len_err;
        logic        phy;
        logic [10:0] len;
    } st_t;

    typedef struct packed {
        logic [7:0] b;
        logic       sof;
    } bq_t;

    bq_t exp_b[$];
    st_t exp_s[$];
    int  n_chk  = 0;
    int  n_fail = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        n_chk++;
        if (act !== req) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, req);
        end
    endtask

    function automatic st_t mk_st(input logic ok, input logic al, input logic le,
                                  input logic ph, input int ln);
        st_t s;
        s.crc_ok  = ok;
        s.align   = al;
        s.len_err = le;
        s.phy     = ph;
        s.len     = 11'(ln);
        return s;
    endfunction

    // Bit-serial LSB-first CRC-32 reference, returns FCS value (complemented).
    function automatic logic [31:0] ref_fcs(input logic [7:0] f[$]);
        logic [31:0] c;
        logic        fb;
        c = 32'hFFFFFFFF;
        foreach (f[i]) begin
            for (int b = 0; b < 8; b++) begin
                fb = f[i][b] ^ c[0];
                c  = c >> 1;
                if (fb) c = c ^ 32'hEDB88320;
            end
        end
        return ~c;
    endfunction

    // Monitor / scoreboard
    initial begin
        logic prev_vld;
        bq_t  eb;
        st_t  es;
        prev_vld = 1'b0;
        forever begin
            @(negedge clk);
            if (rx_byte_valid) begin
                chk("strobe_spacing", 32'(prev_vld), 32'd0);
                if (exp_b.size() == 0) begin
                    n_chk++;
                    n_fail++;
                    $display("FAIL unexpected_byte: got 0x%0h, expected no byte", rx_byte);
                end else begin
                    eb = exp_b.pop_front();
                    chk("rx_byte", 32'(rx_byte), 32'(eb.b));
                    chk("rx_sof", 32'(rx_sof), 32'(eb.sof));
                end
            end
            if (rx_eof) begin
                if (exp_s.size() == 0) begin
                    n_chk++;
                    n_fail++;
                    $display("FAIL unexpected_eof: got rx_eof len=%0d, expected none", rx_len);
                end else begin
                    es = exp_s.pop_front();
                    chk("rx_crc_ok", 32'(rx_crc_ok), 32'(es.crc_ok));
                    chk("rx_align_err", 32'(rx_align_err), 32'(es.align));
                    chk("rx_len_err", 32'(rx_len_err), 32'(es.len_err));
                    chk("rx_phy_err", 32'(rx_phy_err), 32'(es.phy));
                    chk("rx_len", 32'(rx_len), 32'(es.len));
                end
            end
            prev_vld = rx_byte_valid;
        end
    end

    task automatic nib(input logic [3:0] n, input logic er);
        @(posedge clk);
        #1;
        rx_dv = 1'b1;
        rxd   = n;
        rx_er = er;
    endtask

    task automatic idle(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
            rx_dv = 1'b0;
            rxd   = 4'h0;
            rx_er = 1'b0;
        end
    endtask

    // Drives preamble, SFD and frame bytes; leaves rx_dv high (caller ends the frame).
    task automatic send(input logic [7:0] f[$], input int bad_pre, input int er_at,
                        input bit extra, input bit push, input st_t st);
        if (push) begin
            for (int i = 0; i < f.size() - 4; i++) exp_b.push_back({f[i], (i == 0)});
            exp_s.push_back(st);
        end
        for (int i = 0; i < 15; i++) nib((i == bad_pre) ? 4'h7 : 4'h5, 1'b0);
        nib(4'hD, 1'b0);
        for (int i = 0; i < f.size(); i++) begin
            nib(f[i][3:0], (i == er_at));
            nib(f[i][7:4], 1'b0);
        end
        if (extra) nib(4'hA, 1'b0);
    endtask

    task automatic drain(input string name);
        for (int i = 0; i < 400 && (exp_b.size() != 0 || exp_s.size() != 0); i++) begin
            @(negedge clk);
        end
        chk(name, 32'(exp_b.size() + exp_s.size()), 32'd0);
    endtask

    task automatic check_zero(input string name);
        chk({name, "_byte"}, 32'(rx_byte), 32'd0);
        chk({name, "_vld"}, 32'(rx_byte_valid), 32'd0);
        chk({name, "_sof"}, 32'(rx_sof), 32'd0);
        chk({name, "_eof"}, 32'(rx_eof), 32'd0);
        chk({name, "_crc_ok"}, 32'(rx_crc_ok), 32'd0);
        chk({name, "_align"}, 32'(rx_align_err), 32'd0);
        chk({name, "_len_err"}, 32'(rx_len_err), 32'd0);
        chk({name, "_phy"}, 32'(rx_phy_err), 32'd0);
        chk({name, "_len"}, 32'(rx_len), 32'd0);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [7:0]  fa[$];
        logic [7:0]  fb[$];
        logic [7:0]  fc[$];
        logic [31:0] fcs;

        fa = {8'h31, 8'h32, 8'h33, 8'h34, 8'h35, 8'h36, 8'h37, 8'h38, 8'h39,
              8'h26, 8'h39, 8'hF4, 8'hCB};
        fb = fa;
        fb[4] = 8'h34;
        for (int i = 0; i < 60; i++) fc.push_back(8'(i));
        fcs = ref_fcs(fc);
        fc.push_back(fcs[7:0]);
        fc.push_back(fcs[15:8]);
        fc.push_back(fcs[23:16]);
        fc.push_back(fcs[31:24]);

        reset_n = 1'b0;
        rx_dv   = 1'b0;
        rx_er   = 1'b0;
        rxd     = 4'h0;
        #5;
        check_zero("reset");
        repeat (3) @(posedge clk);
        #1;
        reset_n = 1'b1;
        idle(2);

        // Valid short frame: CRC good, too short
        send(fa, -1, -1, 1'b0, 1'b1, mk_st(1'b1, 1'b0, 1'b1, 1'b0, 13));
        idle(3);
        drain("drain_short");

        // Corrupted byte: payload still delivered, CRC fails
        send(fb, -1, -1, 1'b0, 1'b1, mk_st(1'b0, 1'b0, 1'b1, 1'b0, 13));
        idle(3);
        drain("drain_corrupt");

        // Minimum-length valid frame
        send(fc, -1, -1, 1'b0, 1'b1, mk_st(1'b1, 1'b0, 1'b0, 1'b0, 64));
        idle(3);
        drain("drain_64");

        // Same frame plus a dangling nibble
        send(fc, -1, -1, 1'b1, 1'b1, mk_st(1'b0, 1'b1, 1'b0, 1'b0, 64));
        idle(3);
        drain("drain_align");

        // Bad preamble nibble: whole frame ignored
        send(fa, 3, -1, 1'b0, 1'b0, mk_st(1'b0, 1'b0, 1'b0, 1'b0, 0));
        idle(3);
        drain("drain_badpre");

        // rx_er mid-data: flagged but CRC still good
        send(fa, -1, 3, 1'b0, 1'b1, mk_st(1'b1, 1'b0, 1'b1, 1'b1, 13));
        idle(3);
        drain("drain_er");

        // Back-to-back with a single idle cycle
        send(fa, -1, -1, 1'b0, 1'b1, mk_st(1'b1, 1'b0, 1'b1, 1'b0, 13));
        idle(1);
        send(fc, -1, -1, 1'b0, 1'b1, mk_st(1'b1, 1'b0, 1'b0, 1'b0, 64));
        idle(3);
        drain("drain_b2b");
        repeat (3) @(negedge clk);
        chk("status_hold_len", 32'(rx_len), 32'd64);
        chk("status_hold_crc", 32'(rx_crc_ok), 32'd1);

        // Reset mid-payload: bytes 0..5 already released, then abort
        for (int i = 0; i < 6; i++) exp_b.push_back({fc[i], (i == 0)});
        for (int i = 0; i < 15; i++) nib(4'h5, 1'b0);
        nib(4'hD, 1'b0);
        for (int i = 0; i < 10; i++) begin
            nib(fc[i][3:0], 1'b0);
            nib(fc[i][7:4], 1'b0);
        end
        nib(fc[10][3:0], 1'b0);
        @(posedge clk);
        #1;
        reset_n = 1'b0;
        rx_dv   = 1'b0;
        #1;
        check_zero("abort");
        drain("drain_abort");
        repeat (2) @(posedge clk);
        #1;
        reset_n = 1'b1;
        idle(2);

        // Recovery frame after reset
        send(fa, -1, -1, 1'b0, 1'b1, mk_st(1'b1, 1'b0, 1'b1, 1'b0, 13));
        idle(3);
        drain("drain_recover");

        // rx_dv high across reset release: frame dropped
        @(posedge clk);
        #1;
        reset_n = 1'b0;
        rx_dv   = 1'b1;
        rxd     = 4'h5;
        @(posedge clk);
        #1;
        reset_n = 1'b1;
        send(fa, -1, -1, 1'b0, 1'b0, mk_st(1'b0, 1'b0, 1'b0, 1'b0, 0));
        idle(3);
        drain("drain_dv_reset");
        chk("dropped_no_eof_len", 32'(rx_len), 32'd0);

        // And a normal frame afterwards
        send(fc, -1, -1, 1'b0, 1'b1, mk_st(1'b1, 1'b0, 1'b0, 1'b0, 64));
        idle(3);
        drain("drain_final");

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
